// File: rtl/trng_harvester.sv
// Multi-channel entropy harvester: synchronise, sample on a divider tick, XOR-combine,
// optional von Neumann debias, pack into words and gate output with a repetition-count health test.
module trng_harvester #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned REP_LIMIT  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                vn_en,
    input  logic [CHANNELS-1:0] osc_in,
    input  logic [CHANNELS-1:0] chan_mask,
    output logic [WIDTH-1:0]    rnd_data,
    output logic                rnd_valid,
    input  logic                rnd_ready,
    output logic                health_fail
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

    logic [CHANNELS-1:0] r_sync1, r_sync2;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [REP_W-1:0]    r_rep_cnt;
    logic                r_prev_c;
    logic                r_health_fail;
    logic                r_half, r_b0;
    logic [WIDTH-1:0]    r_sr;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WIDTH-1:0]    r_data;
    logic                r_valid;

    logic                w_tick, w_c, w_bit, w_accept, w_fail_set;
    logic                w_word_full, w_word_completing, w_xfer, w_load;
    logic [WIDTH-1:0]    w_shifted, w_word;
    logic [REP_W-1:0]    w_rep_next;

    assign w_tick     = en & (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign w_c        = ^(r_sync2 & chan_mask);
    assign w_fail_set = w_tick & ~r_health_fail & (r_rep_cnt == REP_W'(REP_LIMIT));

    // VN mode emits the first bit of an unequal pair; raw mode emits every sample
    assign w_accept = w_tick & ~r_health_fail & (vn_en ? (r_half & (r_b0 != w_c)) : 1'b1);
    assign w_bit    = vn_en ? r_b0 : w_c;

    assign w_shifted         = {r_sr[WIDTH-2:0], w_bit};
    assign w_word_full       = (r_bit_cnt == CNT_W'(WIDTH));
    assign w_word_completing = w_accept & (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_word            = w_word_full ? r_sr : w_shifted;
    assign w_xfer            = r_valid & rnd_ready;
    assign w_load            = (w_word_full | w_word_completing) & (~r_valid | w_xfer);

    always_comb begin
        w_rep_next = REP_W'(1);
        if (w_c == r_prev_c) begin
            w_rep_next = (r_rep_cnt == REP_W'(REP_LIMIT)) ? r_rep_cnt : r_rep_cnt + REP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= osc_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    // Health test runs on raw combined samples regardless of debiasing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt     <= REP_W'(1);
            r_prev_c      <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (w_tick) begin
            r_rep_cnt <= w_rep_next;
            r_prev_c  <= w_c;
            if (w_fail_set) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half <= 1'b0;
            r_b0   <= 1'b0;
        end else if (!vn_en || w_fail_set) begin
            r_half <= 1'b0;
        end else if (w_tick && !r_health_fail) begin
            if (!r_half) begin
                r_b0   <= w_c;
                r_half <= 1'b1;
            end else begin
                r_half <= 1'b0;
            end
        end
    end

    // Accumulator holds a complete word until the buffer can take it; bits arriving meanwhile drop
    always_ff @(posedge clk) begin
        if (rst || w_fail_set) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_bit_cnt <= '0;
        end else if (w_accept && !w_word_full) begin
            r_sr      <= w_shifted;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_fail_set) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign rnd_data    = r_data;
    assign rnd_valid   = r_valid;
    assign health_fail = r_health_fail;

endmodule
